max_pool_ctrl: RTL and testbench

//   Sequences the combinational max_pool comparator tree over a full feature map held in a

---
 rtl/pool_pkg.sv | 21 ++
 rtl/max_pool_ctrl_if.sv | 27 ++
 rtl/max_pool.sv | 24 ++
 rtl/max_pool_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_max_pool_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// Shared types and constants for the max-pool controller and comparator tree.
package pool_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned FRAC_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        CALC,
        EMIT,
        DONE
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/max_pool_ctrl_if.sv
// Buffer read port plus pooled-result valid/ready stream.
interface max_pool_ctrl_if
    import pool_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = pool_pkg::DATA_W
);

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output rd_en, rd_addr, out_valid, out_data, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data, out_last,
        output rd_data, out_ready
    );

endinterface

// File: rtl/max_pool.sv
// Combinational signed maximum over one WINDOW_SIZE x WINDOW_SIZE window.
module max_pool
    import pool_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE = 4,
    parameter int unsigned DATA_W      = pool_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] win [WINDOW_SIZE*WINDOW_SIZE],
    output logic [DATA_W-1:0] max_c
);

    localparam int unsigned N = WINDOW_SIZE * WINDOW_SIZE;

    // Running signed maximum; ties keep the earlier value, which is equal anyway.
    always_comb begin
        max_c = win[0];
        for (int unsigned i = 1; i < N; i++) begin
            if ($signed(win[i]) > $signed(max_c)) begin
                max_c = win[i];
            end
        end
    end

endmodule

// File: rtl/max_pool_ctrl.sv
// Walks a feature map window by window, gathers each window and streams its maximum.
module max_pool_ctrl
    import pool_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE = 4,
    parameter int unsigned FMAP_W      = 16,
    parameter int unsigned FMAP_H      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = pool_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    max_pool_ctrl_if.master   bus
);

    localparam int unsigned N   = WINDOW_SIZE * WINDOW_SIZE;
    localparam int unsigned OX  = FMAP_W / WINDOW_SIZE;
    localparam int unsigned OY  = FMAP_H / WINDOW_SIZE;
    localparam int unsigned KW  = clog2w(N);
    localparam int unsigned OXW = clog2w(OX);
    localparam int unsigned OYW = clog2w(OY);

    if (((FMAP_W % WINDOW_SIZE) != 0) || ((FMAP_H % WINDOW_SIZE) != 0)) begin : g_cfg_check
        $error("max_pool_ctrl: FMAP_W and FMAP_H must be multiples of WINDOW_SIZE");
    end

    state_t            state, state_nx;
    logic [KW-1:0]     k, k_nx;
    logic [OXW-1:0]    ox, ox_nx;
    logic [OYW-1:0]    oy, oy_nx;
    logic [ADDR_W-1:0] base_q, base_nx;
    logic [ADDR_W-1:0] rd_addr_nx;
    logic              rd_en_nx, out_valid_nx, out_last_nx, busy_nx, done_nx;
    logic              cap_vld, cap_vld_nx;
    logic [KW-1:0]     cap_idx, cap_idx_nx;
    logic              last_win;
    logic [DATA_W-1:0] win [N];
    logic [DATA_W-1:0] pool_max_c;

    // Word address of element kk of window (x, y); wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] calc_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [OXW-1:0]    x,
                                                    input logic [OYW-1:0]    y,
                                                    input logic [KW-1:0]     kk);
        int unsigned row, col;
        row = 32'(y) * WINDOW_SIZE + 32'(kk) / WINDOW_SIZE;
        col = 32'(x) * WINDOW_SIZE + 32'(kk) % WINDOW_SIZE;
        return ADDR_W'(32'(b) + row * FMAP_W + col);
    endfunction

    assign last_win = (ox == OXW'(OX - 1)) && (oy == OYW'(OY - 1));

    // Control state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            k             <= '0;
            ox            <= '0;
            oy            <= '0;
            base_q        <= '0;
            bus.rd_en     <= 1'b0;
            bus.rd_addr   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cap_vld       <= 1'b0;
            cap_idx       <= '0;
        end else begin
            state         <= state_nx;
            k             <= k_nx;
            ox            <= ox_nx;
            oy            <= oy_nx;
            base_q        <= base_nx;
            bus.rd_en     <= rd_en_nx;
            bus.rd_addr   <= rd_addr_nx;
            bus.out_valid <= out_valid_nx;
            bus.out_last  <= out_last_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            cap_vld       <= cap_vld_nx;
            cap_idx       <= cap_idx_nx;
        end
    end

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        state_nx     = state;
        k_nx         = k;
        ox_nx        = ox;
        oy_nx        = oy;
        base_nx      = base_q;
        rd_en_nx     = 1'b0;
        rd_addr_nx   = bus.rd_addr;
        out_valid_nx = bus.out_valid;
        out_last_nx  = bus.out_last;
        busy_nx      = busy;
        done_nx      = 1'b0;
        cap_vld_nx   = bus.rd_en && !abort;
        cap_idx_nx   = k;

        if (abort) begin
            state_nx     = IDLE;
            k_nx         = '0;
            ox_nx        = '0;
            oy_nx        = '0;
            rd_addr_nx   = '0;
            out_valid_nx = 1'b0;
            out_last_nx  = 1'b0;
            busy_nx      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nx   = FETCH;
                        base_nx    = base_addr;
                        busy_nx    = 1'b1;
                        k_nx       = '0;
                        ox_nx      = '0;
                        oy_nx      = '0;
                        rd_en_nx   = 1'b1;
                        rd_addr_nx = calc_addr(base_addr, '0, '0, '0);
                    end
                end
                FETCH: begin
                    if (k == KW'(N - 1)) begin
                        state_nx = CAPT;
                        k_nx     = '0;
                    end else begin
                        k_nx       = k + KW'(1);
                        rd_en_nx   = 1'b1;
                        rd_addr_nx = calc_addr(base_q, ox, oy, k + KW'(1));
                    end
                end
                CAPT: begin
                    state_nx = CALC;
                end
                CALC: begin
                    state_nx     = EMIT;
                    out_valid_nx = 1'b1;
                    out_last_nx  = last_win;
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_nx = 1'b0;
                        out_last_nx  = 1'b0;
                        if (last_win) begin
                            state_nx = DONE;
                            done_nx  = 1'b1;
                        end else begin
                            if (ox == OXW'(OX - 1)) begin
                                ox_nx = '0;
                                oy_nx = oy + OYW'(1);
                            end else begin
                                ox_nx = ox + OXW'(1);
                            end
                            state_nx   = FETCH;
                            rd_en_nx   = 1'b1;
                            rd_addr_nx = calc_addr(base_q, ox_nx, oy_nx, '0);
                        end
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    ox_nx    = '0;
                    oy_nx    = '0;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Window register bank fills one cycle behind each read; result latched in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                win[i] <= '0;
            end
            bus.out_data <= '0;
        end else begin
            if (cap_vld) begin
                win[cap_idx] <= bus.rd_data;
            end
            if ((state == CALC) && !abort) begin
                bus.out_data <= pool_max_c;
            end
        end
    end

    max_pool #(
        .WINDOW_SIZE (WINDOW_SIZE),
        .DATA_W      (DATA_W)
    ) u_max_pool (
        .win   (win),
        .max_c (pool_max_c)
    );

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Directed and randomized checks of max_pool_ctrl against a window-level reference model.
module tb_max_pool_ctrl;
    import pool_pkg::*;

    localparam int WS = 2;
    localparam int FW = 4;
    localparam int FH = 4;
    localparam int N  = WS * WS;
    localparam int NW = (FW / WS) * (FH / WS);

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] base_addr = '0;
    logic        busy, done;

    max_pool_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    max_pool_ctrl #(
        .WINDOW_SIZE (WS),
        .FMAP_W      (FW),
        .FMAP_H      (FH),
        .ADDR_W      (16),
        .DATA_W      (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [65536];
    always_ff @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_out[$];
    logic [15:0] exp_addr[$];
    logic [31:0] got_q[$];
    logic [15:0] addr_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: every non-overlapping window in raster order, signed max of its words.
    function automatic void model(input logic [15:0] base);
        logic signed [31:0] m, v;
        logic [15:0] a;
        exp_out.delete();
        exp_addr.delete();
        for (int oy = 0; oy < FH / WS; oy++) begin
            for (int ox = 0; ox < FW / WS; ox++) begin
                m = '0;
                for (int wy = 0; wy < WS; wy++) begin
                    for (int wx = 0; wx < WS; wx++) begin
                        a = 16'(32'(base) + 32'((oy * WS + wy) * FW + ox * WS + wx));
                        exp_addr.push_back(a);
                        v = $signed(mem[a]);
                        if ((wy == 0 && wx == 0) || v > m) m = v;
                    end
                end
                exp_out.push_back(m);
            end
        end
    endfunction

    // One map pass; optional forced stall on a window, random backpressure, or abort.
    task automatic run_frame(input logic [15:0] base, input int stall_win, input int stall_n,
                             input bit rand_rdy, input int abort_win, input int exp_total);
        int cyc, got, stall_left, first_lat, done_cyc, last_hs;
        bit hold, aborted, fin, any_done;
        logic [31:0] hold_data;
        logic hold_last;
        model(base);
        addr_q.delete();
        got_q.delete();
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; bus.out_ready = 1'b1;
        cyc = 0; got = 0; stall_left = stall_n; first_lat = -1; done_cyc = -1; last_hs = -10;
        hold = 0; aborted = 0; fin = 0; hold_data = '0; hold_last = 1'b0;
        while (!fin && cyc < 400) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; cyc++;
            if (aborted) begin
                chk("abort_busy", 64'(busy), 64'(0));
                chk("abort_rd_en", 64'(bus.rd_en), 64'(0));
                chk("abort_valid", 64'(bus.out_valid), 64'(0));
                any_done = done;
                repeat (N + 4) begin
                    @(posedge clk); #1;
                    any_done |= done;
                end
                chk("abort_no_done", 64'(any_done), 64'(0));
                fin = 1;
            end else begin
                if (bus.rd_en) addr_q.push_back(bus.rd_addr);
                if (hold) begin
                    chk("stall_valid", 64'(bus.out_valid), 64'(1));
                    chk("stall_data", 64'(bus.out_data), 64'(hold_data));
                    chk("stall_last", 64'(bus.out_last), 64'(hold_last));
                end
                if (bus.out_valid && first_lat < 0) first_lat = cyc;
                if (done) begin
                    done_cyc = cyc;
                    fin = 1;
                end else if (abort_win >= 0 && got == abort_win && bus.rd_en) begin
                    abort = 1'b1;
                    aborted = 1;
                end else begin
                    if (bus.out_valid && got == stall_win && stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
                    end
                    hold = bus.out_valid && !bus.out_ready;
                    if (hold) begin
                        hold_data = bus.out_data;
                        hold_last = bus.out_last;
                        chk("stall_no_rd", 64'(bus.rd_en), 64'(0));
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        chk("out_data", 64'(bus.out_data), 64'(got < NW ? exp_out[got] : 32'hDEAD));
                        chk("out_last", 64'(bus.out_last), 64'(got == NW - 1));
                        got_q.push_back(bus.out_data);
                        last_hs = cyc;
                        got++;
                    end
                end
            end
        end
        bus.out_ready = 1'b1;
        if (abort_win < 0) begin
            chk("done_seen", 64'(done_cyc > 0), 64'(1));
            chk("out_count", 64'(got), 64'(NW));
            chk("done_after_hs", 64'(done_cyc), 64'(last_hs + 1));
            chk("first_latency", 64'(first_lat), 64'(N + 3));
            if (exp_total > 0) chk("total_cycles", 64'(done_cyc), 64'(exp_total));
            chk("addr_count", 64'(addr_q.size()), 64'(exp_addr.size()));
            for (int i = 0; i < addr_q.size() && i < exp_addr.size(); i++)
                chk("rd_addr", 64'(addr_q[i]), 64'(exp_addr[i]));
            @(posedge clk); #1;
            chk("done_pulse_1cyc", 64'(done), 64'(0));
            chk("idle_busy", 64'(busy), 64'(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 32'(i);

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_rd_en", 64'(bus.rd_en), 64'(0));
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_last", 64'(bus.out_last), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_addr", 64'(bus.rd_addr), 64'(0));
        chk("rst_data", 64'(bus.out_data), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // start and abort together: abort wins
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'(0));
        chk("start_abort_rd", 64'(bus.rd_en), 64'(0));

        // Ramp map, free-flowing output
        run_frame(16'h0000, -1, 0, 0, -1, NW * (N + 3) + 1);
        chk("ramp_n", 64'(got_q.size()), 64'(4));
        if (got_q.size() == 4) begin
            chk("ramp_0", 64'(got_q[0]), 64'(5));
            chk("ramp_1", 64'(got_q[1]), 64'(7));
            chk("ramp_2", 64'(got_q[2]), 64'(13));
            chk("ramp_3", 64'(got_q[3]), 64'(15));
        end

        // Ten stall cycles on window 1
        run_frame(16'h0000, 1, 10, 0, -1, NW * (N + 3) + 1 + 10);
        if (got_q.size() > 1) chk("stall_win1", 64'(got_q[1]), 64'(7));

        // Signed Q15.16 compare
        mem[0] = 32'hFFFD0000; mem[1] = 32'hFFFE8000; mem[4] = 32'hFFFE0000; mem[5] = 32'hFFF8C000;
        run_frame(16'h0000, -1, 0, 0, -1, NW * (N + 3) + 1);
        if (got_q.size() > 0) chk("neg_max", 64'(got_q[0]), 64'(32'hFFFE8000));
        mem[0] = 32'd0; mem[1] = 32'd1; mem[4] = 32'd4; mem[5] = 32'd5;

        // Address wrap
        run_frame(16'hFFFE, -1, 0, 0, -1, NW * (N + 3) + 1);
        if (addr_q.size() >= 4) begin
            chk("wrap_a0", 64'(addr_q[0]), 64'(16'hFFFE));
            chk("wrap_a1", 64'(addr_q[1]), 64'(16'hFFFF));
            chk("wrap_a2", 64'(addr_q[2]), 64'(16'h0002));
            chk("wrap_a3", 64'(addr_q[3]), 64'(16'h0003));
        end

        // Abort during window 2 fetch, then a clean restart
        run_frame(16'h0000, -1, 0, 0, 2, 0);
        run_frame(16'h0000, -1, 0, 0, -1, NW * (N + 3) + 1);
        if (got_q.size() == 4) begin
            chk("restart_0", 64'(got_q[0]), 64'(5));
            chk("restart_3", 64'(got_q[3]), 64'(15));
        end

        // Start while busy is ignored; async reset during EMIT
        addr_q.delete();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 16'h0000; bus.out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start = (c == 2);
            base_addr = (c == 2) ? 16'h0100 : 16'h0000;
            if (bus.rd_en) addr_q.push_back(bus.rd_addr);
            if (bus.out_valid) break;
        end
        start = 1'b0;
        chk("busy_start_valid", 64'(bus.out_valid), 64'(1));
        chk("busy_start_data", 64'(bus.out_data), 64'(5));
        chk("busy_start_nrd", 64'(addr_q.size()), 64'(4));
        if (addr_q.size() == 4) chk("busy_start_a3", 64'(addr_q[3]), 64'(5));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_data", 64'(bus.out_data), 64'(0));
        chk("async_rst_done", 64'(done), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // Randomized maps, bases and backpressure
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int r = 0; r < 4; r++) begin
            run_frame(16'($urandom), -1, 0, 1, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
